usb_crc16_check: RTL

//  Receive-side CRC16 checker for USB DATA packets in the serial interface engine.

---
 rtl/usb_crc16_check.sv | 196 +++++++++++++++++++
 1 files changed

// File: rtl/usb_crc16_check.sv
// Receive-side USB DATA packet CRC16 checker: bit-serial LSB-first CRC, two-byte holdback, EOP verdict.
// Define USB_CRC16_CHK_STATS_EN to add the saturating errCount output.
module usb_crc16_check #(
    parameter logic [15:0] POLY    = 16'hA001,
    parameter logic [15:0] INIT    = 16'hFFFF,
    parameter logic [15:0] RESIDUE = 16'hB001,
    parameter int unsigned CNT_W   = 10
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             rstCRC,
    input  logic [7:0]       dataIn,
    input  logic             dataValid,
    output logic             dataReady,
    input  logic             eop,
    output logic [7:0]       payloadOut,
    output logic             payloadValid,
    output logic             crcOK,
    output logic             crcErr,
    output logic             shortErr,
    output logic             busy,
    output logic [CNT_W-1:0] byteCount,
    output logic [15:0]      CRCResult
`ifdef USB_CRC16_CHK_STATS_EN
    ,
    output logic [15:0]      errCount
`endif
);

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_SHIFT = 1'b1;

    logic [0:0]       state_q, state_d;
    logic [2:0]       bit_q, bit_d;
    logic [7:0]       sh_q, sh_d;
    logic [15:0]      crc_q, crc_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [7:0]       hb0_q, hb0_d;
    logic [7:0]       hb1_q, hb1_d;
    logic [1:0]       hbn_q, hbn_d;
    logic             pend_q, pend_d;
    logic [7:0]       pout_q, pout_d;
    logic             pval_q, pval_d;
    logic             ok_q, ok_d;
    logic             err_q, err_d;
    logic             short_q, short_d;

    logic             process;
    logic [CNT_W-1:0] cnt_base;
    logic [1:0]       hbn_base;

    function automatic logic [15:0] crc_step(input logic [15:0] c, input logic b);
        if (c[0] ^ b)
            return {1'b0, c[15:1]} ^ POLY;
        else
            return {1'b0, c[15:1]};
    endfunction

    always_comb begin
        state_d  = state_q;
        bit_d    = bit_q;
        sh_d     = sh_q;
        crc_d    = crc_q;
        cnt_d    = cnt_q;
        hb0_d    = hb0_q;
        hb1_d    = hb1_q;
        hbn_d    = hbn_q;
        pend_d   = pend_q;
        pout_d   = pout_q;
        pval_d   = 1'b0;
        ok_d     = 1'b0;
        err_d    = 1'b0;
        short_d  = 1'b0;
        cnt_base = cnt_q;
        hbn_base = hbn_q;
        // A byte offered alongside eop is accepted first; eop then waits until it is shifted.
        process  = (state_q == ST_IDLE) && (pend_q || (eop && !dataValid));

        if (rstCRC) begin
            state_d = ST_IDLE;
            bit_d   = '0;
            crc_d   = INIT;
            cnt_d   = '0;
            hbn_d   = '0;
            pend_d  = 1'b0;
        end else if (state_q == ST_SHIFT) begin
            crc_d = crc_step(crc_q, sh_q[0]);
            sh_d  = {1'b0, sh_q[7:1]};
            bit_d = bit_q + 3'd1;
            if (bit_q == 3'd7)
                state_d = ST_IDLE;
            if (eop)
                pend_d = 1'b1;
        end else begin
            if (process) begin
                if (cnt_q < CNT_W'(2)) begin
                    err_d   = 1'b1;
                    short_d = 1'b1;
                end else if (crc_q == RESIDUE) begin
                    ok_d = 1'b1;
                end else begin
                    err_d = 1'b1;
                end
                crc_d    = INIT;
                cnt_d    = '0;
                hbn_d    = '0;
                pend_d   = 1'b0;
                cnt_base = '0;
                hbn_base = '0;
            end
            // A byte arriving on the verdict edge opens the next packet from a clean state.
            if (dataValid) begin
                case (hbn_base)
                    2'd2: begin
                        pout_d = hb0_q;
                        pval_d = 1'b1;
                        hb0_d  = hb1_q;
                        hb1_d  = dataIn;
                        hbn_d  = 2'd2;
                    end
                    2'd1: begin
                        hb1_d = dataIn;
                        hbn_d = 2'd2;
                    end
                    default: begin
                        hb0_d = dataIn;
                        hbn_d = 2'd1;
                    end
                endcase
                cnt_d   = (cnt_base == '1) ? cnt_base : cnt_base + CNT_W'(1);
                sh_d    = dataIn;
                bit_d   = '0;
                state_d = ST_SHIFT;
                pend_d  = eop;
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= ST_IDLE;
            bit_q   <= '0;
            sh_q    <= '0;
            crc_q   <= INIT;
            cnt_q   <= '0;
            hb0_q   <= '0;
            hb1_q   <= '0;
            hbn_q   <= '0;
            pend_q  <= 1'b0;
            pout_q  <= '0;
            pval_q  <= 1'b0;
            ok_q    <= 1'b0;
            err_q   <= 1'b0;
            short_q <= 1'b0;
        end else begin
            state_q <= state_d;
            bit_q   <= bit_d;
            sh_q    <= sh_d;
            crc_q   <= crc_d;
            cnt_q   <= cnt_d;
            hb0_q   <= hb0_d;
            hb1_q   <= hb1_d;
            hbn_q   <= hbn_d;
            pend_q  <= pend_d;
            pout_q  <= pout_d;
            pval_q  <= pval_d;
            ok_q    <= ok_d;
            err_q   <= err_d;
            short_q <= short_d;
        end
    end

`ifdef USB_CRC16_CHK_STATS_EN
    logic [15:0] errcnt_q;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn)
            errcnt_q <= '0;
        else if (err_d && (errcnt_q != 16'hFFFF))
            errcnt_q <= errcnt_q + 16'd1;
    end

    assign errCount = errcnt_q;
`endif

    assign dataReady    = (state_q == ST_IDLE);
    assign payloadOut   = pout_q;
    assign payloadValid = pval_q;
    assign crcOK        = ok_q;
    assign crcErr       = err_q;
    assign shortErr     = short_q;
    assign busy         = (state_q == ST_SHIFT) || (cnt_q != '0);
    assign byteCount    = cnt_q;
    assign CRCResult    = crc_q;

endmodule
